// File: rtl/fetch_queue_if.sv
// fetch_queue_if: memory request/response, redirect and decode-side handshake bundle
interface fetch_queue_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  modport master (
    output imem_req_valid, imem_req_addr, instr_valid, instr_out, instr_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, instr_ready
  );
  modport slave (
    input  imem_req_valid, imem_req_addr, instr_valid, instr_out, instr_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, instr_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: PC owner issuing in-order imem requests and buffering returned words for decode
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic          clk,
  input logic          rst_n,
  fetch_queue_if.master bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] occ_q, occ_d, out_q, out_d, drop_q, drop_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d, iw_q, iw_d, ir_q, ir_d;
  logic [31:0]   data_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   fl_mem   [DEPTH];
  logic          redir, rsp, acc, pop, push, has_word;
  assign redir    = bus.redirect_valid;
  assign rsp      = bus.imem_rsp_valid;
  assign has_word = occ_q != '0;
  assign bus.imem_req_valid = rst_n && !redir && ({1'b0, occ_q} + {1'b0, out_q} < DEPTH_C);
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.instr_valid    = !redir && has_word;
  assign bus.instr_out      = has_word ? data_mem[rd_q] : '0;
  assign bus.instr_pc       = has_word ? pc_mem[rd_q] : '0;
  assign acc  = bus.imem_req_valid && bus.imem_req_ready;
  assign pop  = bus.instr_valid && bus.instr_ready;
  assign push = rsp && drop_q == '0 && !redir;
  // next state: a redirect flushes the buffer and marks every in-flight response for discard
  always_comb begin
    fetch_pc_d = redir ? (bus.redirect_pc & 32'hFFFF_FFFC) : acc ? fetch_pc_q + 32'd4 : fetch_pc_q;
    out_d      = out_q + CW'(acc) - CW'(rsp);
    drop_d     = redir ? out_q - CW'(rsp) : drop_q - CW'(rsp && drop_q != '0);
    occ_d      = redir ? '0 : occ_q + CW'(push) - CW'(pop);
    wr_d       = wr_q + AW'(push);
    rd_d       = redir ? wr_q : rd_q + AW'(pop);
    iw_d       = iw_q + AW'(acc);
    ir_d       = ir_q + AW'(rsp);
  end
  // control state, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      occ_q      <= '0;
      out_q      <= '0;
      drop_q     <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      iw_q       <= '0;
      ir_q       <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      occ_q      <= occ_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      iw_q       <= iw_d;
      ir_q       <= ir_d;
    end
  // word buffer and in-flight PC buffer; reads are gated by occupancy so no reset is needed
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_q] <= bus.imem_rsp_data;
      pc_mem[wr_q]   <= fl_mem[ir_q];
    end
    if (acc) fl_mem[iw_q] <= fetch_pc_q;
  end
  assert property (@(posedge clk) disable iff (!rst_n) !(push && occ_q == FULL));
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed checks of streaming, backpressure, redirects, wrap and async reset
module tb_fetch_queue;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   lat = 1;
  int   cyc = 0;
  logic        acc_s = 1'b0;
  logic [31:0] addr_s = '0;
  logic [31:0] q_addr[$];
  int          q_due[$];
  fetch_queue_if m ();
  fetch_queue_if m2 ();
  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (.clk(clk), .rst_n(rst_n), .bus(m));
  fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut2 (.clk(clk), .rst_n(rst_n), .bus(m2));
  always #5 clk = ~clk;
  // capture accepted requests mid-cycle
  always @(negedge clk) begin
    acc_s  = rst_n && m.imem_req_valid && m.imem_req_ready;
    addr_s = m.imem_req_addr;
  end
  // in-order memory with lat-cycle response, flushed by reset
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      q_addr.delete();
      q_due.delete();
      m.imem_rsp_valid = 1'b0;
      m.imem_rsp_data  = '0;
    end else begin
      #1;
      cyc++;
      if (acc_s) begin
        q_addr.push_back(addr_s);
        q_due.push_back(cyc - 1 + lat);
      end
      if (q_due.size() > 0 && q_due[0] <= cyc) begin
        m.imem_rsp_valid = 1'b1;
        m.imem_rsp_data  = q_addr.pop_front() ^ 32'hA5A5_0000;
        void'(q_due.pop_front());
      end else begin
        m.imem_rsp_valid = 1'b0;
      end
    end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask
  task automatic sample();
    @(negedge clk);
  endtask
  task automatic reset_to(input int l, input logic rdy);
    @(negedge clk);
    #2 rst_n = 1'b0;
    lat = l;
    m.instr_ready = rdy;
    m.redirect_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    m.imem_req_ready = 1'b1;
    m.redirect_valid = 1'b0;
    m.redirect_pc    = '0;
    m.instr_ready    = 1'b1;
    m2.imem_req_ready = 1'b1;
    m2.imem_rsp_valid = 1'b0;
    m2.imem_rsp_data  = '0;
    m2.redirect_valid = 1'b0;
    m2.redirect_pc    = '0;
    m2.instr_ready    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid", m.imem_req_valid, 0);
    chk("rst_instr_valid", m.instr_valid, 0);
    chk("rst_instr_out", m.instr_out, 0);
    chk("rst_instr_pc", m.instr_pc, 0);
    chk("rst_req_valid2", m2.imem_req_valid, 0);
    // streaming with 1-cycle memory; dut2 checks the PC wrap
    @(posedge clk);
    #1 rst_n = 1'b1;
    sample();
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin
        next_cycle();
        sample();
      end
      chk("str_req_valid", m.imem_req_valid, 1);
      chk("str_req_addr", m.imem_req_addr, 32'(4 * k));
      chk("str_instr_valid", m.instr_valid, k >= 2 ? 1 : 0);
      if (k >= 2) begin
        chk("str_instr_pc", m.instr_pc, 32'(4 * (k - 2)));
        chk("str_instr_out", m.instr_out, 32'(4 * (k - 2)) ^ 32'hA5A5_0000);
      end
      if (k < 4) begin
        chk("wrap_req_valid", m2.imem_req_valid, 1);
        chk("wrap_req_addr", m2.imem_req_addr, 32'hFFFF_FFF8 + 32'(4 * k));
      end
      if (k == 4) chk("wrap_credit_stop", m2.imem_req_valid, 0);
    end
    // backpressure: four requests fill the credit, then drain in order
    reset_to(1, 1'b0);
    sample();
    for (int k = 0; k < 7; k++) begin
      if (k > 0) begin
        next_cycle();
        sample();
      end
      chk("bp_req_valid", m.imem_req_valid, k < 4 ? 1 : 0);
      if (k < 4) chk("bp_req_addr", m.imem_req_addr, 32'(4 * k));
      if (k >= 2) chk("bp_hold_pc", m.instr_pc, 0);
      if (k == 5) chk("bp_occ", 32'(dut.occ_q), 4);
    end
    next_cycle();
    m.instr_ready = 1'b1;
    sample();
    chk("bp_release_req", m.imem_req_valid, 0);
    chk("bp_release_pc", m.instr_pc, 0);
    for (int k = 8; k < 12; k++) begin
      next_cycle();
      sample();
      chk("bp_drain_pc", m.instr_pc, 32'(4 * (k - 7)));
      if (k == 8) begin
        chk("bp_resume_valid", m.imem_req_valid, 1);
        chk("bp_resume_addr", m.imem_req_addr, 32'h10);
      end
    end
    chk("bp_drain_out", m.instr_out, 32'hA5A5_0010);
    // async reset with three words buffered and a request pending
    reset_to(1, 1'b0);
    sample();
    next_cycle();
    sample();
    next_cycle();
    sample();
    next_cycle();
    m.imem_req_ready = 1'b0;
    sample();
    next_cycle();
    sample();
    chk("ar_pre_valid", m.instr_valid, 1);
    chk("ar_pre_req", m.imem_req_valid, 1);
    chk("ar_pre_occ", 32'(dut.occ_q), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_instr_valid", m.instr_valid, 0);
    chk("ar_req_valid", m.imem_req_valid, 0);
    chk("ar_instr_out", m.instr_out, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    m.imem_req_ready = 1'b1;
    m.instr_ready = 1'b1;
    sample();
    chk("ar_restart_addr", m.imem_req_addr, 32'h0);
    chk("ar_restart_valid", m.imem_req_valid, 1);
    chk("ar_no_stale0", m.instr_valid, 0);
    next_cycle();
    sample();
    chk("ar_no_stale1", m.instr_valid, 0);
    next_cycle();
    sample();
    chk("ar_first_valid", m.instr_valid, 1);
    chk("ar_first_out", m.instr_out, 32'hA5A5_0000);
    // redirect with two requests in flight on a 3-cycle memory
    reset_to(3, 1'b1);
    sample();
    next_cycle();
    sample();
    next_cycle();
    m.redirect_valid = 1'b1;
    m.redirect_pc = 32'h103;
    sample();
    chk("rd_outstanding", 32'(dut.out_q), 2);
    chk("rd_req_blocked", m.imem_req_valid, 0);
    chk("rd_instr_blocked", m.instr_valid, 0);
    next_cycle();
    m.redirect_valid = 1'b0;
    sample();
    chk("rd_target_valid", m.imem_req_valid, 1);
    chk("rd_target_addr", m.imem_req_addr, 32'h100);
    for (int k = 3; k < 7; k++) begin
      if (k > 3) begin
        next_cycle();
        sample();
      end
      chk("rd_dropped", m.instr_valid, 0);
    end
    next_cycle();
    sample();
    chk("rd_first_valid", m.instr_valid, 1);
    chk("rd_first_pc", m.instr_pc, 32'h100);
    chk("rd_first_out", m.instr_out, 32'hA5A5_0100);
    next_cycle();
    sample();
    chk("rd_second_pc", m.instr_pc, 32'h104);
    // redirect coincident with a response
    reset_to(1, 1'b0);
    sample();
    next_cycle();
    sample();
    next_cycle();
    m.redirect_valid = 1'b1;
    m.redirect_pc = 32'h200;
    sample();
    chk("co_rsp_present", m.imem_rsp_valid, 1);
    chk("co_instr_blocked", m.instr_valid, 0);
    next_cycle();
    m.redirect_valid = 1'b0;
    m.instr_ready = 1'b1;
    sample();
    chk("co_empty", m.instr_valid, 0);
    chk("co_occ", 32'(dut.occ_q), 0);
    chk("co_target_addr", m.imem_req_addr, 32'h200);
    next_cycle();
    sample();
    chk("co_empty2", m.instr_valid, 0);
    next_cycle();
    sample();
    chk("co_first_pc", m.instr_pc, 32'h200);
    chk("co_first_out", m.instr_out, 32'hA5A5_0200);
    // back-to-back redirects: the later target wins
    reset_to(3, 1'b1);
    sample();
    next_cycle();
    sample();
    next_cycle();
    m.redirect_valid = 1'b1;
    m.redirect_pc = 32'h300;
    sample();
    next_cycle();
    m.redirect_pc = 32'h402;
    sample();
    chk("bb_req_blocked", m.imem_req_valid, 0);
    next_cycle();
    m.redirect_valid = 1'b0;
    sample();
    chk("bb_target_addr", m.imem_req_addr, 32'h400);
    for (int k = 5; k < 8; k++) begin
      next_cycle();
      sample();
      chk("bb_dropped", m.instr_valid, 0);
    end
    next_cycle();
    sample();
    chk("bb_first_pc", m.instr_pc, 32'h400);
    chk("bb_first_out", m.instr_out, 32'hA5A5_0400);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
